// File: rtl/hpdcache_stream_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hpdcache_stream_mux_pkg
// Purpose  : Shared helpers for the stream multiplexer and its arbiter.
// Contents : sel_width() - width of a binary channel index, never below 1.
// Revision : 1.0 - initial release
// ============================================================================
package hpdcache_stream_mux_pkg;

  // A single channel still needs a 1-bit index so that ports never collapse
  // to zero width.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hpdcache_stream_arb.sv
`default_nettype none
// ============================================================================
// Module   : hpdcache_stream_arb
// Purpose  : Grant generator for hpdcache_stream_mux. Fixed-priority or
//            round-robin selection, packet lock across multi-beat packets,
//            and a held grant while an offered beat waits for acceptance.
// Ports    : clk_i, rst_ni  - clock, asynchronous active-low reset
//            i_valid[N]     - per-channel valid
//            i_last[N]      - per-channel last flag
//            i_accept       - the granted channel transfers this cycle
//            i_hold         - the granted channel is offering but not accepted
//            o_gnt[N]       - one-hot grant (all zero while in reset)
// Revision : 1.0 - initial release
// ============================================================================
module hpdcache_stream_arb
  import hpdcache_stream_mux_pkg::*;
#(
  parameter int NINPUT = 4,
  parameter int RR_ARB = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NINPUT-1:0] i_valid,
  input  logic [NINPUT-1:0] i_last,
  input  logic              i_accept,
  input  logic              i_hold,
  output logic [NINPUT-1:0] o_gnt
);

  localparam int SEL_WIDTH = int'(sel_width(NINPUT));

  logic [NINPUT-1:0]    r_gnt;
  logic                 r_lock;
  logic                 r_hold;
  logic [SEL_WIDTH-1:0] r_ptr;

  logic [NINPUT-1:0]    w_arb;
  logic [NINPUT-1:0]    w_gnt;
  logic [SEL_WIDTH-1:0] w_start;
  logic [SEL_WIDTH-1:0] w_gnt_idx;
  logic                 w_last;

  // Scan from the farthest candidate back to the start point so that the
  // channel closest to the start (in wrap order) is the final winner.
  always_comb begin
    int idx;
    w_arb   = '0;
    w_start = (RR_ARB != 0) ? r_ptr : '0;
    for (int k = NINPUT - 1; k >= 0; k--) begin
      idx = int'(w_start) + k;
      if (idx >= NINPUT) idx = idx - NINPUT;
      if (i_valid[idx]) begin
        w_arb      = '0;
        w_arb[idx] = 1'b1;
      end
    end
  end

  // A locked packet or a pending un-accepted beat pins the previous grant.
  assign w_gnt = (r_lock || r_hold) ? r_gnt : w_arb;
  assign o_gnt = w_gnt & {NINPUT{rst_ni}};

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NINPUT; i++) begin
      if (w_gnt[i]) w_gnt_idx = w_gnt_idx | SEL_WIDTH'(i);
    end
  end

  assign w_last = |(i_last & w_gnt);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_gnt  <= '0;
      r_lock <= 1'b0;
      r_hold <= 1'b0;
      r_ptr  <= '0;
    end else begin
      r_gnt  <= w_gnt;
      r_hold <= i_hold;
      if (i_accept) begin
        r_lock <= !w_last;
        if (w_last) begin
          r_ptr <= (w_gnt_idx == SEL_WIDTH'(NINPUT - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hpdcache_stream_mux.sv
`default_nettype none
// ============================================================================
// Module   : hpdcache_stream_mux
// Purpose  : N-to-1 valid/ready stream multiplexer with packet-aware
//            arbitration and an optional one-entry output register.
// Ports    : clk_i, rst_ni          - clock, asynchronous active-low reset
//            valid_i/ready_o[N]     - per-channel handshake
//            data_i[N][DATA_WIDTH]  - per-channel payload
//            last_i[N]              - per-channel end-of-packet
//            valid_o/ready_i        - output handshake
//            data_o, last_o         - selected payload and last flag
//            sel_o                  - binary index of the output beat source
// Revision : 1.0 - initial release
// ============================================================================
module hpdcache_stream_mux
  import hpdcache_stream_mux_pkg::*;
#(
  parameter int NINPUT     = 4,
  parameter int DATA_WIDTH = 64,
  parameter int RR_ARB     = 1,
  parameter int OUTPUT_REG = 1,
  localparam int SEL_WIDTH = int'(sel_width(NINPUT))
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NINPUT-1:0]                    valid_i,
  output logic [NINPUT-1:0]                    ready_o,
  input  logic [NINPUT-1:0][DATA_WIDTH-1:0]    data_i,
  input  logic [NINPUT-1:0]                    last_i,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic [DATA_WIDTH-1:0]                data_o,
  output logic                                 last_o,
  output logic [SEL_WIDTH-1:0]                 sel_o
);

  logic [NINPUT-1:0]     w_gnt;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_last;
  logic [SEL_WIDTH-1:0]  w_sel;
  logic                  w_in_valid;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_hold;

  hpdcache_stream_arb #(
    .NINPUT (NINPUT),
    .RR_ARB (RR_ARB)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_valid  (valid_i),
    .i_last   (last_i),
    .i_accept (w_accept),
    .i_hold   (w_hold),
    .o_gnt    (w_gnt)
  );

  // One-hot AND-OR selection; the grant is all zero in reset, so every
  // selected field is zero there as well.
  always_comb begin
    w_data = '0;
    w_last = 1'b0;
    w_sel  = '0;
    for (int i = 0; i < NINPUT; i++) begin
      w_data = w_data | (data_i[i] & {DATA_WIDTH{w_gnt[i]}});
      w_last = w_last | (last_i[i] & w_gnt[i]);
      if (w_gnt[i]) w_sel = w_sel | SEL_WIDTH'(i);
    end
  end

  assign w_in_valid = |(valid_i & w_gnt);
  assign w_accept   = w_in_valid & w_in_ready;
  assign w_hold     = w_in_valid & !w_in_ready;
  assign ready_o    = w_gnt & {NINPUT{w_in_ready}};

  generate
    if (OUTPUT_REG != 0) begin : g_reg
      logic                  r_valid;
      logic [DATA_WIDTH-1:0] r_data;
      logic                  r_last;
      logic [SEL_WIDTH-1:0]  r_sel;

      assign w_in_ready = !r_valid | ready_i;

      // The register is writable whenever it is empty or draining; without
      // a new beat it simply empties.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_valid <= 1'b0;
          r_data  <= '0;
          r_last  <= 1'b0;
          r_sel   <= '0;
        end else if (w_in_ready) begin
          r_valid <= w_accept;
          if (w_accept) begin
            r_data <= w_data;
            r_last <= w_last;
            r_sel  <= w_sel;
          end
        end
      end

      assign valid_o = r_valid;
      assign data_o  = r_data;
      assign last_o  = r_last;
      assign sel_o   = r_sel;
    end else begin : g_comb
      assign w_in_ready = ready_i;
      assign valid_o    = w_in_valid;
      assign data_o     = w_data;
      assign last_o     = w_last;
      assign sel_o      = w_sel;
    end
  endgenerate

`ifndef SYNTHESIS
  generate
    for (genvar i = 0; i < NINPUT; i++) begin : g_in_assert
      a_in_stable : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (valid_i[i] && !ready_o[i]) |=>
          (valid_i[i] && $stable(data_i[i]) && $stable(last_i[i]))
      );
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_hpdcache_stream_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_hpdcache_stream_mux
// Purpose  : Directed self-checking bench. Three instances: A fixed/comb,
//            B round-robin/comb, C round-robin/registered.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hpdcache_stream_mux;

  localparam int N  = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]         a_valid, a_last, a_ready;
  logic [N-1:0][DW-1:0] a_data;
  logic                 a_rdy_in, a_vo, a_lo;
  logic [DW-1:0]        a_do;
  logic [1:0]           a_so;

  logic [N-1:0]         b_valid, b_last, b_ready;
  logic [N-1:0][DW-1:0] b_data;
  logic                 b_rdy_in, b_vo, b_lo;
  logic [DW-1:0]        b_do;
  logic [1:0]           b_so;

  logic [N-1:0]         c_valid, c_last, c_ready;
  logic [N-1:0][DW-1:0] c_data;
  logic                 c_rdy_in, c_vo, c_lo;
  logic [DW-1:0]        c_do;
  logic [1:0]           c_so;

  int checks = 0;
  int errors = 0;

  hpdcache_stream_mux #(.NINPUT(N), .DATA_WIDTH(DW), .RR_ARB(0), .OUTPUT_REG(0)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(a_valid), .ready_o(a_ready), .data_i(a_data),
    .last_i(a_last), .valid_o(a_vo), .ready_i(a_rdy_in), .data_o(a_do), .last_o(a_lo), .sel_o(a_so));

  hpdcache_stream_mux #(.NINPUT(N), .DATA_WIDTH(DW), .RR_ARB(1), .OUTPUT_REG(0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(b_valid), .ready_o(b_ready), .data_i(b_data),
    .last_i(b_last), .valid_o(b_vo), .ready_i(b_rdy_in), .data_o(b_do), .last_o(b_lo), .sel_o(b_so));

  hpdcache_stream_mux #(.NINPUT(N), .DATA_WIDTH(DW), .RR_ARB(1), .OUTPUT_REG(1)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(c_valid), .ready_o(c_ready), .data_i(c_data),
    .last_i(c_last), .valid_o(c_vo), .ready_i(c_rdy_in), .data_o(c_do), .last_o(c_lo), .sel_o(c_so));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_valid = 4'b0001; a_last = 4'b1111; a_data = '0; a_data[0] = 16'h1111; a_rdy_in = 1'b1;
    b_valid = '0;      b_last = '0;      b_data = '0; b_rdy_in = 1'b1;
    c_valid = 4'b0001; c_last = 4'b1111; c_data = '0; c_data[0] = 16'h1234; c_rdy_in = 1'b1;
    sample();
    checks++;
    if ({a_vo, a_lo, a_so, a_do} !== 20'h0) begin
      errors++; $display("FAIL reset_a_out: got %h expected 0", {a_vo, a_lo, a_so, a_do});
    end
    checks++;
    if ({c_vo, c_lo, c_so, c_do} !== 20'h0) begin
      errors++; $display("FAIL reset_c_out: got %h expected 0", {c_vo, c_lo, c_so, c_do});
    end
    checks++;
    if (c_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_c_ready: got %b expected 0000", c_ready);
    end
    tick();
    a_valid = '0; c_valid = '0;
    tick();
    rst_n = 1'b1;
    sample();
    checks++;
    if (c_vo !== 1'b0) begin
      errors++; $display("FAIL reset_c_idle: got %b expected 0", c_vo);
    end
  endtask

  task automatic test_fixed_priority;
    a_rdy_in = 1'b1; a_last = 4'b1111;
    a_data[1] = 16'h00A1; a_data[3] = 16'h00A3;
    a_valid = 4'b1010;
    sample();
    checks++;
    if ({a_vo, a_so, a_do} !== {1'b1, 2'd1, 16'h00A1}) begin
      errors++; $display("FAIL fixed_beat0: got %h expected %h", {a_vo, a_so, a_do}, {1'b1, 2'd1, 16'h00A1});
    end
    tick();
    a_valid[1] = 1'b0;
    sample();
    checks++;
    if ({a_vo, a_so, a_do} !== {1'b1, 2'd3, 16'h00A3}) begin
      errors++; $display("FAIL fixed_beat1: got %h expected %h", {a_vo, a_so, a_do}, {1'b1, 2'd3, 16'h00A3});
    end
    tick();
    a_valid[3] = 1'b0;
    sample();
    checks++;
    if (a_vo !== 1'b0) begin
      errors++; $display("FAIL fixed_idle: got %b expected 0", a_vo);
    end
  endtask

  task automatic test_comb_hold;
    a_rdy_in = 1'b0; a_last = 4'b1111;
    a_data[3] = 16'h00B3; a_valid = 4'b1000;
    sample();
    checks++;
    if ({a_vo, a_so, a_do} !== {1'b1, 2'd3, 16'h00B3}) begin
      errors++; $display("FAIL hold_offer: got %h expected %h", {a_vo, a_so, a_do}, {1'b1, 2'd3, 16'h00B3});
    end
    tick();
    a_valid[0] = 1'b1; a_data[0] = 16'h00B0;
    sample();
    checks++;
    if ({a_vo, a_so, a_do, a_ready} !== {1'b1, 2'd3, 16'h00B3, 4'b0000}) begin
      errors++; $display("FAIL hold_pinned: got %h expected %h", {a_vo, a_so, a_do, a_ready}, {1'b1, 2'd3, 16'h00B3, 4'b0000});
    end
    tick();
    a_rdy_in = 1'b1;
    sample();
    checks++;
    if ({a_so, a_do, a_ready} !== {2'd3, 16'h00B3, 4'b1000}) begin
      errors++; $display("FAIL hold_accept: got %h expected %h", {a_so, a_do, a_ready}, {2'd3, 16'h00B3, 4'b1000});
    end
    tick();
    a_valid[3] = 1'b0;
    sample();
    checks++;
    if ({a_vo, a_so, a_do, a_ready} !== {1'b1, 2'd0, 16'h00B0, 4'b0001}) begin
      errors++; $display("FAIL hold_next: got %h expected %h", {a_vo, a_so, a_do, a_ready}, {1'b1, 2'd0, 16'h00B0, 4'b0001});
    end
    tick();
    a_valid[0] = 1'b0;
  endtask

  task automatic test_round_robin;
    int cnt [N];
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      b_data[i] = 16'h00C0 + 16'(i);
    end
    b_rdy_in = 1'b1; b_last = 4'b1111; b_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      sample();
      checks++;
      if ({b_vo, b_so, b_do} !== {1'b1, 2'(k % N), 16'h00C0 + 16'(k % N)}) begin
        errors++; $display("FAIL rr_seq%0d: got %h expected %h", k, {b_vo, b_so, b_do}, {1'b1, 2'(k % N), 16'h00C0 + 16'(k % N)});
      end
      if (b_vo === 1'b1) cnt[b_so] = cnt[b_so] + 1;
      tick();
      if (k >= N) b_valid[k % N] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cnt[i] !== 2) begin
        errors++; $display("FAIL rr_fair_ch%0d: got %0d grants expected 2", i, cnt[i]);
      end
    end
  endtask

  task automatic test_packet_lock;
    b_rdy_in = 1'b1;
    b_last = 4'b0000; b_data[2] = 16'h00D1; b_valid = 4'b0100;
    sample();
    checks++;
    if ({b_vo, b_so, b_do, b_lo} !== {1'b1, 2'd2, 16'h00D1, 1'b0}) begin
      errors++; $display("FAIL lock_beat0: got %h expected %h", {b_vo, b_so, b_do, b_lo}, {1'b1, 2'd2, 16'h00D1, 1'b0});
    end
    tick();
    b_data[2] = 16'h00D2; b_data[0] = 16'h00E0; b_last[0] = 1'b1; b_valid[0] = 1'b1;
    sample();
    checks++;
    if ({b_so, b_do, b_ready} !== {2'd2, 16'h00D2, 4'b0100}) begin
      errors++; $display("FAIL lock_beat1: got %h expected %h", {b_so, b_do, b_ready}, {2'd2, 16'h00D2, 4'b0100});
    end
    tick();
    b_valid[2] = 1'b0;
    sample();
    checks++;
    if ({b_vo, b_ready} !== {1'b0, 4'b0100}) begin
      errors++; $display("FAIL lock_gap: got %h expected %h", {b_vo, b_ready}, {1'b0, 4'b0100});
    end
    tick();
    b_valid[2] = 1'b1; b_data[2] = 16'h00D3; b_last[2] = 1'b1;
    sample();
    checks++;
    if ({b_vo, b_so, b_do, b_lo} !== {1'b1, 2'd2, 16'h00D3, 1'b1}) begin
      errors++; $display("FAIL lock_beat2: got %h expected %h", {b_vo, b_so, b_do, b_lo}, {1'b1, 2'd2, 16'h00D3, 1'b1});
    end
    tick();
    b_valid[2] = 1'b0;
    sample();
    checks++;
    if ({b_vo, b_so, b_do, b_ready} !== {1'b1, 2'd0, 16'h00E0, 4'b0001}) begin
      errors++; $display("FAIL lock_release: got %h expected %h", {b_vo, b_so, b_do, b_ready}, {1'b1, 2'd0, 16'h00E0, 4'b0001});
    end
    tick();
    b_valid[0] = 1'b0;
  endtask

  task automatic test_reg_backpressure;
    c_rdy_in = 1'b0; c_last = 4'b1111;
    c_data[0] = 16'h0055; c_valid = 4'b0001;
    sample();
    checks++;
    if ({c_vo, c_ready} !== {1'b0, 4'b0001}) begin
      errors++; $display("FAIL reg_load: got %h expected %h", {c_vo, c_ready}, {1'b0, 4'b0001});
    end
    tick();
    c_valid = 4'b0010; c_data[1] = 16'h0066;
    for (int k = 0; k < 5; k++) begin
      sample();
      checks++;
      if ({c_vo, c_so, c_do, c_ready} !== {1'b1, 2'd0, 16'h0055, 4'b0000}) begin
        errors++; $display("FAIL reg_stall%0d: got %h expected %h", k, {c_vo, c_so, c_do, c_ready}, {1'b1, 2'd0, 16'h0055, 4'b0000});
      end
      tick();
    end
    c_rdy_in = 1'b1; c_valid[2] = 1'b1; c_data[2] = 16'h0077;
    sample();
    checks++;
    if ({c_vo, c_do, c_ready} !== {1'b1, 16'h0055, 4'b0010}) begin
      errors++; $display("FAIL reg_resume: got %h expected %h", {c_vo, c_do, c_ready}, {1'b1, 16'h0055, 4'b0010});
    end
    tick();
    c_valid[1] = 1'b0;
    sample();
    checks++;
    if ({c_vo, c_so, c_do, c_ready} !== {1'b1, 2'd1, 16'h0066, 4'b0100}) begin
      errors++; $display("FAIL reg_b2b0: got %h expected %h", {c_vo, c_so, c_do, c_ready}, {1'b1, 2'd1, 16'h0066, 4'b0100});
    end
    tick();
    c_valid[2] = 1'b0;
    sample();
    checks++;
    if ({c_vo, c_so, c_do} !== {1'b1, 2'd2, 16'h0077}) begin
      errors++; $display("FAIL reg_b2b1: got %h expected %h", {c_vo, c_so, c_do}, {1'b1, 2'd2, 16'h0077});
    end
    tick();
    sample();
    checks++;
    if (c_vo !== 1'b0) begin
      errors++; $display("FAIL reg_drain: got %b expected 0", c_vo);
    end
  endtask

  task automatic test_reset_mid_packet;
    b_rdy_in = 1'b1;
    b_last = 4'b0000; b_data[1] = 16'h00F1; b_valid = 4'b0010;
    sample();
    checks++;
    if ({b_vo, b_so, b_do} !== {1'b1, 2'd1, 16'h00F1}) begin
      errors++; $display("FAIL rstmid_beat0: got %h expected %h", {b_vo, b_so, b_do}, {1'b1, 2'd1, 16'h00F1});
    end
    tick();
    b_data[1] = 16'h00F2;
    rst_n = 1'b0;
    sample();
    checks++;
    if ({b_vo, b_lo, b_so, b_do, b_ready} !== 24'h0) begin
      errors++; $display("FAIL rstmid_out: got %h expected 0", {b_vo, b_lo, b_so, b_do, b_ready});
    end
    tick();
    b_valid = 4'b0011; b_last = 4'b0011;
    b_data[0] = 16'h00F0; b_data[1] = 16'h0061;
    tick();
    rst_n = 1'b1;
    sample();
    checks++;
    if ({b_vo, b_so, b_do} !== {1'b1, 2'd0, 16'h00F0}) begin
      errors++; $display("FAIL rstmid_first: got %h expected %h", {b_vo, b_so, b_do}, {1'b1, 2'd0, 16'h00F0});
    end
    tick();
    b_valid[0] = 1'b0;
    sample();
    checks++;
    if ({b_vo, b_so, b_do, b_lo} !== {1'b1, 2'd1, 16'h0061, 1'b1}) begin
      errors++; $display("FAIL rstmid_second: got %h expected %h", {b_vo, b_so, b_do, b_lo}, {1'b1, 2'd1, 16'h0061, 1'b1});
    end
    tick();
    b_valid[1] = 1'b0;
    sample();
    checks++;
    if (b_vo !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: got %b expected 0", b_vo);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_comb_hold();
    test_round_robin();
    test_packet_lock();
    test_reg_backpressure();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hpdcache_stream_mux.md
Name: hpdcache_stream_mux

Overview:
- Parametrised N-to-1 stream multiplexer with valid/ready handshakes on every input and on the output.
- Arbitrates internally, fixed-priority or round-robin, and keeps the grant across multi-beat packets delimited by a last flag.
- Optionally registers the output with one-cycle latency and full throughput.
- Placement: any point in the cache datapath where several request or refill streams merge onto one channel, e.g. miss-handler and write-buffer requests toward the memory interface.

Parameters:
- NINPUT, 4: number of input channels, >=1.
- DATA_WIDTH, 64: payload width in bits, >=1.
- RR_ARB, 1: 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
- OUTPUT_REG, 1: 1 = registered output; 0 = combinational pass-through.
- SEL_WIDTH (localparam): max(1, $clog2(NINPUT)).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  NINPUT  per-channel beat valid.
- ready_o  out  NINPUT  per-channel beat accepted.
- data_i  in  NINPUT x DATA_WIDTH  per-channel payload, packed array.
- last_i  in  NINPUT  final beat of the packet.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream ready.
- data_o  out  DATA_WIDTH  selected payload.
- last_o  out  1  selected last flag.
- sel_o  out  SEL_WIDTH  binary index of the source of the current output beat.

Behaviour:
- **Transfer definitions.** Input transfer on channel i: valid_i[i] & ready_o[i]. Output transfer: valid_o & ready_i.
- **Input rules.** Once valid_i[i] is raised it stays high, with data_i/last_i stable, until that channel transfers. A simulation-only assertion flags violations.
- **Grant.** At most one ready_o bit is high in any cycle. ready_o[j]=0 for every non-granted j.
- **Arbitration.** Happens only when the block is unlocked and no un-accepted beat is pending.
  - Fixed mode: lowest-index valid channel wins.
  - RR mode: first valid channel at or after the priority pointer ptr_q, wrapping from NINPUT-1 to 0.
- **Packet lock.**
  - Accepting a beat with last=0 sets lock_q and pins the grant to that channel.
  - Accepting a beat with last=1 clears lock_q.
  - While locked, other channels are never granted, even if the locked channel drops valid between beats.
- **RR pointer.** On input acceptance of a last=1 beat from channel g, ptr_q <= (g+1) mod NINPUT. Non-last beats leave ptr_q unchanged.
- **Output stability.** An offered but un-accepted output beat keeps valid_o, data_o, last_o and sel_o unchanged until the output transfer.
- **OUTPUT_REG=0 (combinational).**
  - valid_o = valid_i[g]; data_o, last_o and sel_o are driven from channel g; ready_o[g] = ready_i.
  - Zero latency.
  - The grant is held in a register while valid_o & !ready_i, so a later higher-priority request cannot change the output.
- **OUTPUT_REG=1 (registered).**
  - One-entry output register holding valid, data, last and sel.
  - ready_o[g] = !valid_q | ready_i.
  - On input transfer, the register loads next cycle. Latency is one cycle; back-to-back beats run at one per cycle.
  - If the output transfers with no input transfer, valid_q clears.
  - Simultaneous input and output transfer: the register reloads and valid_q stays 1.
- **Data path.** One-hot AND-OR selection of data_i/last_i by the grant vector. sel_o is the binary encoding of that grant.
- **Reset (asynchronous, any time, including mid-packet).**
  - valid_o=0, last_o=0, data_o=0, sel_o=0.
  - lock_q=0, ptr_q=0, held grant cleared.
  - A partially transferred packet is abandoned; no recovery is attempted.
  - ready_o is 0 during reset in registered mode.
- **NINPUT=1.** Degenerate pass-through or register stage; sel_o is constant 0.
- **Idle.** No input valid and unlocked: valid_o falls after the pending beat drains.

Decomposition:
- No new shared-package types. SEL_WIDTH and grant vectors are derived locally from the parameters.
- One sub-module, hpdcache_stream_arb. It holds the fixed/RR priority selection, the ptr_q pointer, lock_q and the held grant. Its interface is valid vector, last vector, accept pulse and hold request in; one-hot grant out.
- The data selection and output register stay in hpdcache_stream_mux.

Test Plan:
1. **Fixed priority.** RR_ARB=0, OUTPUT_REG=0, NINPUT=4. Channels 1 and 3 valid single-beat (last=1), data 0xA1/0xA3, ready_i=1 → cycle 0 outputs 0xA1 with sel_o=1; cycle 1 outputs 0xA3 with sel_o=3.
2. **Round-robin fairness.** RR_ARB=1, all 4 channels continuously valid with single-beat packets, ready_i=1 → sel_o sequence 0,1,2,3,0,1 and no channel starved.
3. **Packet lock.** Channel 2 sends 3 beats (last=0,0,1) while channel 0 is valid throughout → sel_o=2 for 3 consecutive accepted beats, then 0; ptr_q=3 after the last beat.
4. **Registered back-pressure.** OUTPUT_REG=1. Single beat 0x55 accepted, ready_i held low 5 cycles → valid_o=1 and data_o=0x55 stable for 5 cycles; ready_o all 0 during the stall; throughput 1 beat/cycle restored once ready_i=1.
5. **Combinational hold.** OUTPUT_REG=0, RR_ARB=0. Channel 3 offered with ready_i=0; channel 0 raises valid next cycle → sel_o stays 3 until accepted; channel 0 is granted afterwards.
6. **Reset mid-packet.** rst_ni low after 1 of 3 beats from channel 1 → valid_o=0, lock cleared, ptr_q=0 immediately. After release, channel 0 (valid) is granted first.
